// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache. Hits return combinationally; a miss
// issues a single read to the memory controller and holds until iwait drops.
module icache #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iinv,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned TW  = 30 - IDX;

  typedef enum logic {StIdle, StMiss} state_e;

  state_e            state_q, state_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [TW-1:0]     tag_q [SETS];
  logic [31:0]       data_q [SETS];
  logic [31:0]       miss_addr_q, miss_addr_d;
  logic              pend_q, pend_d;
  logic              fill_we;
  logic [IDX-1:0]    req_idx, fill_idx;
  logic [TW-1:0]     req_tag, fill_tag;
  logic              lookup_hit;
  logic              unused_low_bits;

  assign req_idx    = imemaddr[IDX+1:2];
  assign req_tag    = imemaddr[31:IDX+2];
  assign fill_idx   = miss_addr_q[IDX+1:2];
  assign fill_tag   = miss_addr_q[31:IDX+2];
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_low_bits = ^imemaddr[1:0];

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    miss_addr_d = miss_addr_q;
    pend_d      = pend_q;
    fill_we     = 1'b0;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    unique case (state_q)
      StIdle: begin
        // An invalidate outranks both a hit and a new miss in the same cycle.
        if (iinv) begin
          valid_d = '0;
        end else if (imemREN) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data_q[req_idx];
          end else begin
            miss_addr_d = {imemaddr[31:2], 2'b00};
            state_d     = StMiss;
          end
        end
      end
      StMiss: begin
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (iinv) pend_d = 1'b1;
        if (!iwait) begin
          // A fence seen at any point of the miss discards the returning word.
          if (pend_q || iinv) begin
            valid_d = '0;
          end else begin
            valid_d[fill_idx] = 1'b1;
            fill_we           = 1'b1;
          end
          pend_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      miss_addr_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
      pend_q      <= pend_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed vector table, reset-mid-miss sequence, then random traffic
// checked against a frame-level reference model.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iinv;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  icache #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iinv(iinv),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
    .iload(iload)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        inv;
    logic        wt;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_data;
    logic        e_ren;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: each frame remembers the full word address it holds.
  bit          mv [16];
  logic [29:0] mw [16];
  logic [31:0] md [16];
  bit          m_miss, m_pend;
  logic [31:0] m_addr;

  function automatic vec_t v(input logic ren, input logic [31:0] addr, input logic inv,
                             input logic wt, input logic [31:0] ld, input logic eh,
                             input logic [31:0] ed, input logic er, input logic [31:0] ea);
    vec_t r;
    r.ren = ren; r.addr = addr; r.inv = inv; r.wt = wt; r.ld = ld;
    r.e_hit = eh; r.e_data = ed; r.e_ren = er; r.e_iaddr = ea;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mv[i]) mv[i] = 1'b0;
    m_miss = 1'b0;
    m_pend = 1'b0;
    m_addr = '0;
  endtask

  function automatic bit model_hit(input logic [31:0] addr);
    return mv[addr[5:2]] && (mw[addr[5:2]] == addr[31:2]);
  endfunction

  task automatic model_exp(input logic ren, input logic [31:0] addr, input logic inv,
                           output logic eh, output logic [31:0] ed, output logic er,
                           output logic [31:0] ea);
    if (m_miss) begin
      eh = 1'b0; ed = '0; er = 1'b1; ea = m_addr;
    end else begin
      eh = ren && !inv && model_hit(addr);
      ed = eh ? md[addr[5:2]] : 32'h0;
      er = 1'b0; ea = '0;
    end
  endtask

  task automatic model_step(input logic ren, input logic [31:0] addr, input logic inv,
                            input logic wt, input logic [31:0] ld);
    if (!m_miss) begin
      if (inv) foreach (mv[i]) mv[i] = 1'b0;
      else if (ren && !model_hit(addr)) begin
        m_miss = 1'b1;
        m_addr = {addr[31:2], 2'b00};
      end
    end else begin
      if (inv) m_pend = 1'b1;
      if (!wt) begin
        if (m_pend) foreach (mv[i]) mv[i] = 1'b0;
        else begin
          mv[m_addr[5:2]] = 1'b1;
          mw[m_addr[5:2]] = m_addr[31:2];
          md[m_addr[5:2]] = ld;
        end
        m_miss = 1'b0;
        m_pend = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive just after posedge, check at negedge, advance model at posedge.
  task automatic cyc(input logic ren, input logic [31:0] addr, input logic inv,
                     input logic wt, input logic [31:0] ld, input logic eh,
                     input logic [31:0] ed, input logic er, input logic [31:0] ea,
                     input string nm);
    imemREN = ren; imemaddr = addr; iinv = inv; iwait = wt; iload = ld;
    @(negedge CLK);
    check({nm, ".ihit"}, {31'b0, ihit}, {31'b0, eh});
    check({nm, ".imemload"}, imemload, ed);
    check({nm, ".iREN"}, {31'b0, iREN}, {31'b0, er});
    check({nm, ".iaddr"}, iaddr, ea);
    @(posedge CLK);
    model_step(ren, addr, inv, wt, ld);
    #1;
  endtask

  initial begin
    logic        eh, er, r, inv, wt;
    logic [31:0] ed, ea, a, ld;

    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iinv = 1'b0; iwait = 1'b1; iload = '0;
    model_reset();

    // Cold miss: 3 busy cycles then data; hit on the next cycle.
    vecs.push_back(v(1, 32'h40, 0, 1, 0, 0, 0, 0, 0));
    repeat (3) vecs.push_back(v(1, 32'h40, 0, 1, 0, 0, 0, 1, 32'h40));
    vecs.push_back(v(1, 32'h40, 0, 0, 32'hDEADBEEF, 0, 0, 1, 32'h40));
    vecs.push_back(v(1, 32'h40, 0, 1, 0, 1, 32'hDEADBEEF, 0, 0));
    // Conflict eviction through the shared index.
    vecs.push_back(v(1, 32'h440, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 32'h440, 0, 0, 32'h11110440, 0, 0, 1, 32'h440));
    vecs.push_back(v(1, 32'h440, 0, 1, 0, 1, 32'h11110440, 0, 0));
    vecs.push_back(v(1, 32'h40, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 32'h40, 0, 0, 32'hDEADBEEF, 0, 0, 1, 32'h40));
    vecs.push_back(v(1, 32'h40, 0, 1, 0, 1, 32'hDEADBEEF, 0, 0));
    // Redirect and request drop mid-miss.
    vecs.push_back(v(1, 32'h100, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 32'h104, 0, 1, 0, 0, 0, 1, 32'h100));
    vecs.push_back(v(0, 32'h104, 0, 1, 0, 0, 0, 1, 32'h100));
    vecs.push_back(v(1, 32'h104, 0, 0, 32'h22220100, 0, 0, 1, 32'h100));
    vecs.push_back(v(1, 32'h104, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 32'h100, 0, 1, 0, 0, 0, 1, 32'h104));
    vecs.push_back(v(1, 32'h100, 0, 0, 32'h33330104, 0, 0, 1, 32'h104));
    vecs.push_back(v(1, 32'h100, 0, 1, 0, 1, 32'h22220100, 0, 0));
    vecs.push_back(v(1, 32'h107, 0, 1, 0, 1, 32'h33330104, 0, 0));
    // Invalidate during a miss: fill discarded, everything misses afterwards.
    vecs.push_back(v(1, 32'h200, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 32'h200, 1, 1, 0, 0, 0, 1, 32'h200));
    vecs.push_back(v(1, 32'h200, 0, 1, 0, 0, 0, 1, 32'h200));
    vecs.push_back(v(1, 32'h200, 0, 0, 32'h44440200, 0, 0, 1, 32'h200));
    vecs.push_back(v(1, 32'h200, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 32'h200, 0, 0, 32'h44440200, 0, 0, 1, 32'h200));
    vecs.push_back(v(1, 32'h104, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 32'h104, 0, 0, 32'h33330104, 0, 0, 1, 32'h104));
    // Invalidate in idle masks the hit and starts no miss.
    vecs.push_back(v(1, 32'h104, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 32'h104, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 32'h104, 0, 0, 32'h33330104, 0, 0, 1, 32'h104));
    // Hit streaming over four consecutive words.
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(v(1, 32'(4 * i), 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(1, 32'(4 * i), 0, 0, 32'h50000000 | 32'(4 * i), 0, 0, 1, 32'(4 * i)));
    end
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(1, 32'(4 * i), 0, 1, 0, 1, 32'h50000000 | 32'(4 * i), 0, 0));
    vecs.push_back(v(0, 32'h0, 0, 1, 0, 0, 0, 0, 0));

    #2;
    check("reset.ihit", {31'b0, ihit}, 32'h0);
    check("reset.imemload", imemload, 32'h0);
    check("reset.iREN", {31'b0, iREN}, 32'h0);
    check("reset.iaddr", iaddr, 32'h0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      cyc(vecs[i].ren, vecs[i].addr, vecs[i].inv, vecs[i].wt, vecs[i].ld, vecs[i].e_hit,
          vecs[i].e_data, vecs[i].e_ren, vecs[i].e_iaddr, $sformatf("vec%0d", i));

    // Reset mid-miss: request drops asynchronously; previously valid words miss afterwards.
    cyc(1, 32'h300, 0, 1, 0, 0, 0, 0, 0, "rst_miss_start");
    #2;
    check("rst_miss.iREN_before", {31'b0, iREN}, 32'h1);
    nRST = 1'b0;
    #1;
    check("rst_miss.iREN", {31'b0, iREN}, 32'h0);
    check("rst_miss.ihit", {31'b0, ihit}, 32'h0);
    check("rst_miss.iaddr", iaddr, 32'h0);
    model_reset();
    @(posedge CLK);
    #1 nRST = 1'b1;
    cyc(1, 32'h8, 0, 1, 0, 0, 0, 0, 0, "after_rst_miss");
    cyc(1, 32'h8, 0, 0, 32'h0BADF00D, 0, 0, 1, 32'h8, "after_rst_fill");
    cyc(1, 32'h8, 0, 1, 0, 1, 32'h0BADF00D, 0, 0, "after_rst_hit");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) < 80);
      inv = ($urandom_range(0, 99) < 3);
      wt  = 1'($urandom_range(0, 1));
      ld  = $urandom;
      a   = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a[31] = 1'b1;
      model_exp(r, a, inv, eh, ed, er, ea);
      cyc(r, a, inv, wt, ld, eh, ed, er, ea, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
